axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-aware round-robin arbiter that shares one AXI4-Stream sink, typically the write side of the stream FIFO, between `NUM_SRC` AXI4-Stream sources. It grants one source at a time and holds the grant for a whole packet, until that source's TLast beat is accepted. After each packet it rotates priority so that every requester is served in bounded time. The block sits between the upstream producers and the FIFO's S_* port.

## Interface
- `NUM_SRC`, default 4: number of requesting sources, ≥2.
- `width`, default 8: TData width; matches the FIFO width.
- `CLK` input 1: clock; all logic is on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `S_TData` input NUM_SRC*width: source data; source i occupies bits [i*width +: width].
- `S_TValid` input NUM_SRC: per-source valid.
- `S_TLast` input NUM_SRC: per-source end-of-packet.
- `S_TReady` output NUM_SRC: per-source ready; at most one bit is high at a time.
- `M_TData` output width: granted source's data, toward the FIFO.
- `M_TValid` output 1: granted source's valid.
- `M_TLast` output 1: granted source's TLast.
- `M_TReady` input 1: sink ready, from the FIFO's S_TReady.
- `M_TDest` output $clog2(NUM_SRC): index of the currently granted source.
- `isBusy` output 1: high while in GRANT; for debug.

## Operation
- FSM has two states, IDLE and GRANT.
- **IDLE:**
  - If any `S_TValid` bit is high, select the first valid source, searching from `lastGrant+1` upward modulo NUM_SRC.
  - Register the selection into `grant`, then go to GRANT.
  - If no source is valid, stay in IDLE.
- **GRANT:**
  - Outputs are a combinational mux of source `grant`: `M_TData`, `M_TValid`, `M_TLast`.
  - `S_TReady[grant] = M_TReady`; all other ready bits are 0.
  - A beat transfers when `S_TValid[grant] && M_TReady`.
  - When a transfer carries `S_TLast[grant]=1`: set `lastGrant <= grant` and go to IDLE.
- **Grant lock:**
  - The grant is held until the TLast beat transfers.
  - Deassertion of `S_TValid[grant]` mid-packet does not release the grant, and other sources wait.
- **IDLE outputs:** `M_TValid=0`, `M_TLast=0`, `M_TData='0`, `S_TReady='0`, `isBusy=0`.
- **Wrap-around:** the search index wraps from NUM_SRC-1 to 0. `lastGrant` resets to NUM_SRC-1, so source 0 has first priority after reset.
- **Single requester:** the same source can be re-granted on every arbitration.
- **Reset values:**
  - State: IDLE.
  - `grant=0`, `M_TDest=0`, `lastGrant=NUM_SRC-1`.
  - All outputs are at their IDLE values.
  - Reset overrides any transfer in the same cycle.
  - A packet in flight at reset is truncated, and the sink sees no further beats from it.
- **No buffering:** the block holds no data. AXI rules pass through from source to sink: data is stable while valid is high and ready is low.

## Timing
- Arbitration latency is 1 cycle. A valid seen in IDLE at edge N makes the source granted from cycle N+1. Its first beat can transfer in cycle N+1.
- There is exactly one IDLE bubble cycle after every TLast beat. Peak rates:
  - Single-beat packets: 1 beat per 2 cycles.
  - L-beat packets: L beats per L+1 cycles.
- Paths `M_TReady -> S_TReady` and `S_* -> M_*` are combinational; there is no register on the data path.
- `M_TDest` is registered and is stable for the full packet.
- Worst-case wait for a requesting source is (NUM_SRC-1) packets plus their bubbles.

## Structure
- **Package `axis_pkg`:**
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
  - Index-width helper function, `$clog2(NUM_SRC)`, shared with the FIFO benches.
- **Sub-module `rr_priority_encoder`:**
  - Parameter: `NUM_SRC`.
  - Inputs: `req[NUM_SRC]`, `last[$clog2]`.
  - Outputs: `sel[$clog2]`, `any`.
  - Purely combinational rotate-and-find-first.
- The top level holds the FSM, the `grant`/`lastGrant` registers and the output mux.

## Test plan
All scenarios use NUM_SRC=4, width=8.
1. After reset, sources 0 and 2 each hold one single-beat packet (0xA0, 0xC2), `M_TReady=1` -> 0xA0 with `M_TDest=0`, one bubble, then 0xC2 with `M_TDest=2`.
2. All four sources hold single-beat packets continuously -> `M_TDest` sequence 0,1,2,3,0,1,… with `M_TValid` high on every other cycle.
3. Source 1 sends a 3-beat packet (0x11, 0x12, 0x13 with TLast) while source 0 requests -> all three beats of source 1 appear contiguously. Source 0 is granted only after the 0x13 beat plus one bubble.
4. `M_TReady=0` for 3 cycles mid-packet -> `S_TReady[grant]=0`, and `M_TData`/`M_TLast` hold the source's stable values. No beat is lost or duplicated.
5. The granted source drops `S_TValid` for 2 cycles mid-packet while source 3 is valid -> the grant stays and `M_TValid=0`. Source 3 is not served until the original TLast.
6. `Reset` asserted on the second beat of a 4-beat packet -> next cycle IDLE, `S_TReady=0`, `M_TValid=0`, `M_TDest=0`. A later request from source 0 is granted first.

Source files
------------

// File: rtl/axis_rr_arbiter_pkg.sv
// axis_pkg: shared FSM state type and index-width helper for the stream arbiter and FIFO benches
package axis_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: N-source AXI4-Stream fan-in bundle; master is the arbiter view, slave the environment view
interface axis_rr_arbiter_if import axis_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int width   = 8
);
    localparam int IW = idx_w(NUM_SRC);
    logic [NUM_SRC*width-1:0] S_TData;
    logic [NUM_SRC-1:0]       S_TValid;
    logic [NUM_SRC-1:0]       S_TLast;
    logic [NUM_SRC-1:0]       S_TReady;
    logic [width-1:0]         M_TData;
    logic                     M_TValid;
    logic                     M_TLast;
    logic                     M_TReady;
    logic [IW-1:0]            M_TDest;
    logic                     isBusy;
    modport master (
        input  S_TData, S_TValid, S_TLast, M_TReady,
        output S_TReady, M_TData, M_TValid, M_TLast, M_TDest, isBusy
    );
    modport slave (
        output S_TData, S_TValid, S_TLast, M_TReady,
        input  S_TReady, M_TData, M_TValid, M_TLast, M_TDest, isBusy
    );
endinterface

// File: rtl/axis_rr_arbiter_rr_priority_encoder.sv
// rr_priority_encoder: finds the first set request strictly after index last, wrapping modulo NUM_SRC
module rr_priority_encoder import axis_pkg::*; #(
    parameter int NUM_SRC = 4,
    localparam int IW = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      sel,
    output logic               any
);
    // Scan farthest-first so the nearest requester after last overwrites earlier hits
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_SRC]) begin
                sel = IW'((int'(last) + k) % NUM_SRC);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin arbiter sharing one AXI4-Stream sink among NUM_SRC sources
module axis_rr_arbiter import axis_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int width   = 8
) (
    input logic CLK,
    input logic Reset,
    axis_rr_arbiter_if.master bus
);
    localparam int IW = idx_w(NUM_SRC);
    arb_state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, sel;
    logic any, busy, xfer;
    rr_priority_encoder #(.NUM_SRC(NUM_SRC)) u_enc (
        .req  (bus.S_TValid),
        .last (last_grant_q),
        .sel  (sel),
        .any  (any)
    );
    assign busy = (state_q == GRANT);
    assign xfer = busy && bus.S_TValid[grant_q] && bus.M_TReady;
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (!busy) begin
            if (any) begin
                state_d = GRANT;
                grant_d = sel;
            end
        end else if (xfer && bus.S_TLast[grant_q]) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
        end
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end
    assign bus.M_TData  = busy ? bus.S_TData[int'(grant_q)*width +: width] : '0;
    assign bus.M_TValid = busy && bus.S_TValid[grant_q];
    assign bus.M_TLast  = busy && bus.S_TLast[grant_q];
    assign bus.S_TReady = busy ? (NUM_SRC'(bus.M_TReady) << grant_q) : '0;
    assign bus.M_TDest  = grant_q;
    assign bus.isBusy   = busy;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed checks of grant order, packet lock, backpressure and reset truncation
module tb_axis_rr_arbiter;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    axis_rr_arbiter_if #(.NUM_SRC(4), .width(8)) bus ();
    axis_rr_arbiter #(.NUM_SRC(4), .width(8)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask
    task automatic src(input int i, input logic v, input logic l, input logic [7:0] d);
        bus.S_TValid[i]       = v;
        bus.S_TLast[i]        = l;
        bus.S_TData[i*8 +: 8] = d;
    endtask
    task automatic idle_chk(input string tag);
        #1;
        chk({tag, "_valid"}, 32'(bus.M_TValid), 0);
        chk({tag, "_busy"}, 32'(bus.isBusy), 0);
        chk({tag, "_ready"}, 32'(bus.S_TReady), 0);
        chk({tag, "_data"}, 32'(bus.M_TData), 0);
    endtask
    task automatic beat_chk(input string tag, input int dest, input logic [7:0] d, input logic l);
        #1;
        chk({tag, "_valid"}, 32'(bus.M_TValid), 1);
        chk({tag, "_dest"}, 32'(bus.M_TDest), 32'(dest));
        chk({tag, "_data"}, 32'(bus.M_TData), 32'(d));
        chk({tag, "_last"}, 32'(bus.M_TLast), 32'(l));
        chk({tag, "_ready"}, 32'(bus.S_TReady), 32'(4'(1) << dest));
    endtask
    initial begin
        bus.S_TData = '0; bus.S_TValid = '0; bus.S_TLast = '0; bus.M_TReady = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        idle_chk("rst");
        chk("rst_dest", 32'(bus.M_TDest), 0);
        // 1: sources 0 and 2, one beat each
        src(0, 1, 1, 8'hA0); src(2, 1, 1, 8'hC2);
        idle_chk("t1_pre");
        tick(); beat_chk("t1_a0", 0, 8'hA0, 1);
        tick(); src(0, 0, 0, 8'h00); idle_chk("t1_bub");
        tick(); beat_chk("t1_c2", 2, 8'hC2, 1);
        tick(); src(2, 0, 0, 8'h00); idle_chk("t1_end");
        // 2: all four continuously valid, single-beat packets
        Reset = 1'b1; tick(); Reset = 1'b0;
        for (int i = 0; i < 4; i++) src(i, 1, 1, 8'(8'h40 + i));
        for (int k = 0; k < 8; k++) begin
            tick(); beat_chk("t2_beat", k % 4, 8'(8'h40 + k % 4), 1);
            tick(); idle_chk("t2_bub");
        end
        for (int i = 0; i < 4; i++) src(i, 0, 0, 8'h00);
        tick(); idle_chk("t2_end");
        // 3: 3-beat packet from source 1 while source 0 waits
        src(1, 1, 0, 8'h11);
        tick(); src(0, 1, 1, 8'h0A); beat_chk("t3_b1", 1, 8'h11, 0);
        tick(); src(1, 1, 0, 8'h12); beat_chk("t3_b2", 1, 8'h12, 0);
        tick(); src(1, 1, 1, 8'h13); beat_chk("t3_b3", 1, 8'h13, 1);
        tick(); src(1, 0, 0, 8'h00); idle_chk("t3_bub");
        tick(); beat_chk("t3_s0", 0, 8'h0A, 1);
        tick(); src(0, 0, 0, 8'h00); idle_chk("t3_end");
        // 4: sink backpressure for 3 cycles mid-packet
        src(2, 1, 0, 8'h21);
        tick(); bus.M_TReady = 1'b0; #1;
        chk("t4_rdy0", 32'(bus.S_TReady), 0);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("t4_hold_data", 32'(bus.M_TData), 32'h21);
            chk("t4_hold_last", 32'(bus.M_TLast), 0);
            chk("t4_hold_rdy", 32'(bus.S_TReady), 0);
        end
        bus.M_TReady = 1'b1; beat_chk("t4_b1", 2, 8'h21, 0);
        tick(); src(2, 1, 1, 8'h22); beat_chk("t4_b2", 2, 8'h22, 1);
        tick(); src(2, 0, 0, 8'h00); idle_chk("t4_end");
        // 5: granted source stalls its valid while source 3 waits
        src(0, 1, 0, 8'h51);
        tick(); src(3, 1, 1, 8'h3F); beat_chk("t5_b1", 0, 8'h51, 0);
        tick(); src(0, 0, 0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_gap_valid", 32'(bus.M_TValid), 0);
            chk("t5_gap_dest", 32'(bus.M_TDest), 0);
            chk("t5_gap_busy", 32'(bus.isBusy), 1);
            tick();
        end
        src(0, 1, 1, 8'h52); beat_chk("t5_b2", 0, 8'h52, 1);
        tick(); src(0, 0, 0, 8'h00); #1;
        chk("t5_bub_valid", 32'(bus.M_TValid), 0);
        tick(); beat_chk("t5_s3", 3, 8'h3F, 1);
        tick(); src(3, 0, 0, 8'h00); idle_chk("t5_end");
        // 6: reset on second beat of a 4-beat packet
        src(1, 1, 0, 8'h61);
        tick(); beat_chk("t6_b1", 1, 8'h61, 0);
        tick(); src(1, 1, 0, 8'h62); Reset = 1'b1; beat_chk("t6_b2", 1, 8'h62, 0);
        tick(); Reset = 1'b0; src(1, 1, 0, 8'h63); src(0, 1, 1, 8'h06);
        idle_chk("t6_rst");
        chk("t6_rst_dest", 32'(bus.M_TDest), 0);
        tick(); beat_chk("t6_s0", 0, 8'h06, 1);
        tick(); src(0, 0, 0, 8'h00); src(1, 0, 0, 8'h00); idle_chk("t6_end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
